muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide controller for the MIPS core, sitting beside the single-cycle ALU in the execute stage. It sequences a shared 33-bit add/subtract step over 32 iterations to implement MULT/MULTU/DIV/DIVU, and owns the architectural HI/LO registers, including MTHI/MTLO writes. The decode/stall logic launches operations with `start` and stalls HI/LO readers while `busy` is high.

## Interface
Parameters:
- none; the iteration count is fixed at 32.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled on each rising edge.
- `fncode`  in  funct_t  operation: FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI or FUNCT_MTLO.
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  32  rt operand: multiplier or divisor.
- `busy`  out  1  an operation is in progress; new requests are ignored.
- `done`  out  1  single-cycle pulse; HI/LO now hold the result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, mul/div fncode:
  - Latch the operand magnitudes. Signed ops use the two's-complement absolute value; unsigned ops use raw values.
  - Latch the result signs: quotient/product sign = a[31]^b[31]; remainder sign = a[31]. Both are 0 for unsigned ops.
  - Clear the 6-bit iteration counter and go to RUN.
- RUN, multiply: one shift-add step per cycle on the 64-bit {acc, mplier} pair (LSB-first).
- RUN, divide: one restoring step per cycle (shift the remainder left, trial-subtract the divisor, set the quotient bit when non-negative).
- RUN exit: after the 32nd step, go to FIX.
- FIX:
  - Apply the sign fix-ups: negate the 64-bit product, or negate the quotient/remainder independently.
  - Write HI/LO: mult → {hi,lo} = product; div → lo = quotient, hi = remainder.
  - Assert `done` for the next cycle and go to IDLE.
- IDLE, `start`=1, MTHI/MTLO: write `a` to hi (MTHI) or lo (MTLO) at that edge. No busy, no done.
- `start` with any other fncode, or while in RUN/FIX: ignored, no state change.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=a. Full latency still applies.
- Signed 0x80000000 / -1: lo=0x80000000, hi=0. This is the natural magnitude-path result.
- Operand inputs are ignored after acceptance.
- HI/LO are not modified during RUN. They update only in FIX or on MTHI/MTLO.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0. Reset is asynchronous and can occur mid-RUN; the operation is abandoned.
- Start accepted at edge E0. RUN spans E1–E32; FIX executes at E33.
- `busy` is registered: high after E0 until E33. That is 33 cycles high for every mul/div.
- `done` and the new hi/lo are visible after E33, for exactly one cycle; `busy` is 0 in that cycle.
- Back-to-back: a `start` in the `done` cycle is accepted (state is IDLE).
- MTHI/MTLO: value visible after the sampling edge. Latency 1.
- `busy` and `done` are never both high.

## Structure
- Add FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO and FUNCT_MFHI/FUNCT_MFLO to funct_t in the shared CPU package, next to the existing FUNCT_ADDU group.
- Define the state enum `muldiv_state_t` (IDLE, RUN, FIX) in the same package.
- Optional combinational sub-module `muldiv_step`: takes {acc, shreg, operand, is_div} and returns the next {acc, shreg}. It holds the shared 33-bit adder/subtractor; the FSM and HI/LO live in `muldiv_unit`.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after E33: hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles; one done pulse.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007.
- MULTU 3×4 started; then `start`=1 with DIVU 100/7 at E10 → ignored, result is hi=0, lo=12. DIVU 100/7 issued in the done cycle → hi=2, lo=14, done 34 cycles later.
- rst_n low mid-RUN (cycle 10) → busy=0, hi=lo=0 immediately, no done pulse. After release, MTHI a=0x12345678 → hi=0x12345678 next cycle, busy stays 0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the execute stage: funct codes and the
// multiply/divide controller state encoding.
package muldiv_unit_pkg;

    typedef enum logic [5:0] {
        FUNCT_MFHI  = 6'h10,
        FUNCT_MTHI  = 6'h11,
        FUNCT_MFLO  = 6'h12,
        FUNCT_MTLO  = 6'h13,
        FUNCT_MULT  = 6'h18,
        FUNCT_MULTU = 6'h19,
        FUNCT_DIV   = 6'h1A,
        FUNCT_DIVU  = 6'h1B,
        FUNCT_ADD   = 6'h20,
        FUNCT_ADDU  = 6'h21,
        FUNCT_SUB   = 6'h22,
        FUNCT_SUBU  = 6'h23
    } funct_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } muldiv_state_t;

    localparam int unsigned MD_STEPS = 32;

    function automatic logic is_muldiv(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
               (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_div_op(input funct_t f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_op(input funct_t f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide, built around a
// single shared 33-bit adder/subtractor.
module muldiv_step
    import muldiv_unit_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [31:0] shreg,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [31:0] acc_next,
    output logic [31:0] shreg_next
);

    logic [32:0] lhs;
    logic [32:0] rhs;
    logic [32:0] sum;
    logic [32:0] sel;

    always_comb begin
        lhs = is_div ? {acc, shreg[31]} : {1'b0, acc};
        rhs = is_div ? ~{1'b0, operand} : {1'b0, operand};
        sum = lhs + rhs + {32'd0, is_div};
        sel = '0;
        if (is_div) begin
            // sum[32] is the borrow: set means the trial subtract went negative
            acc_next   = sum[32] ? lhs[31:0] : sum[31:0];
            shreg_next = {shreg[30:0], ~sum[32]};
        end else begin
            sel        = shreg[0] ? sum : lhs;
            acc_next   = sel[32:1];
            shreg_next = {sel[0], shreg[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers;
// operates on magnitudes and applies sign fix-ups in a final cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  funct_t      fncode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state, state_next;
    logic [5:0]  count;
    logic [31:0] acc, shreg, operand;
    logic [31:0] acc_step, shreg_step;
    logic        is_div, neg_q, neg_r;
    logic        accept, sgn;
    logic [31:0] mag_a, mag_b;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    muldiv_step u_step (
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .is_div     (is_div),
        .acc_next   (acc_step),
        .shreg_next (shreg_step)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: if (start && is_muldiv(fncode)) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN:  if (count == 6'(MD_STEPS - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sgn      = is_signed_op(fncode);
        mag_a    = (sgn && a[31]) ? -a : a;
        mag_b    = (sgn && b[31]) ? -b : b;
        prod_fix = neg_q ? -{acc, shreg} : {acc, shreg};
        quot_fix = neg_q ? -shreg : shreg;
        rem_fix  = neg_r ? -acc : acc;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            shreg   <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX);
            if (accept) begin
                count   <= '0;
                acc     <= '0;
                is_div  <= is_div_op(fncode);
                shreg   <= is_div_op(fncode) ? mag_a : mag_b;
                operand <= is_div_op(fncode) ? mag_b : mag_a;
                // A zero divisor keeps the all-ones quotient unnegated
                neg_q   <= sgn && (a[31] ^ b[31]) && !(is_div_op(fncode) && (b == '0));
                neg_r   <= sgn && a[31];
            end else if (state == IDLE && start && fncode == FUNCT_MTHI) begin
                hi <= a;
            end else if (state == IDLE && start && fncode == FUNCT_MTLO) begin
                lo <= a;
            end else if (state == RUN) begin
                acc   <= acc_step;
                shreg <= shreg_step;
                count <= count + 6'd1;
            end else if (state == FIX) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quot_fix;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomised checks of muldiv_unit against a native-arithmetic
// model, with expected HI/LO pairs queued at issue and popped at done.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    funct_t      fncode = FUNCT_ADDU;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int failed = 0;
    logic [63:0] sb[$];

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fncode (fncode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input funct_t f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            FUNCT_MULTU: return {32'd0, x} * {32'd0, y};
            FUNCT_MULT:  return 64'(sx * sy);
            FUNCT_DIVU:  if (y == 0) return {x, 32'hFFFFFFFF};
                         else return {x % y, x / y};
            FUNCT_DIV:   if (y == 0) return {x, 32'hFFFFFFFF};
                         else return {32'(sx % sy), 32'(sx / sy)};
            default:     return '0;
        endcase
    endfunction

    // Entered and left on a negedge; returns in the done cycle.
    task automatic do_op(input funct_t f, input logic [31:0] x, input logic [31:0] y, input int inject);
        int lat, bc;
        logic [31:0] hold_hi, hold_lo;
        logic [63:0] exp;
        sb.push_back(model(f, x, y));
        hold_hi = hi;
        hold_lo = lo;
        start = 1'b1; fncode = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        bc = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            check("hilo_hold", {hi, lo}, {hold_hi, hold_lo});
            start = (lat == inject);
            if (lat == inject) begin
                fncode = FUNCT_DIVU; a = 32'd100; b = 32'd7;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_latency", 64'(lat), 64'd34);
        check("busy_cycles", 64'(bc), 64'd33);
        check("busy_at_done", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check("hi", {32'd0, hi}, {32'd0, exp[63:32]});
            check("lo", {32'd0, lo}, {32'd0, exp[31:0]});
        end
    endtask

    initial begin
        funct_t rf [4] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
        int dcount;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        do_op(FUNCT_MULT, 32'hFFFFFFFD, 32'd7, -1);
        @(negedge clk);
        do_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd2, -1);
        @(negedge clk);
        do_op(FUNCT_DIVU, 32'd7, 32'd0, -1);
        @(negedge clk);
        do_op(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF, -1);
        @(negedge clk);
        do_op(FUNCT_DIV, 32'hFFFFFFF9, 32'd0, -1);
        @(negedge clk);

        do_op(FUNCT_MULTU, 32'd3, 32'd4, 10);
        do_op(FUNCT_DIVU, 32'd100, 32'd7, -1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_op(rf[i % 4], $urandom, (i == 5) ? 32'(i + 1) : $urandom, -1);
            @(negedge clk);
        end

        // Non-mul/div funct must be ignored in IDLE
        start = 1'b1; fncode = FUNCT_ADDU; a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        check("ignored_busy", 64'(busy), 64'd0);

        // Abandon an operation with an asynchronous reset mid-RUN
        start = 1'b1; fncode = FUNCT_MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", {32'd0, hi}, 64'd0);
        check("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("arst_no_done", 64'(dcount), 64'd0);

        start = 1'b1; fncode = FUNCT_MTHI; a = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'h12345678);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        start = 1'b1; fncode = FUNCT_MTLO; a = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'hCAFEF00D);
        check("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);
        check("mtlo_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
